// File: rtl/fc_argmax_pkg.sv
// Shared types and constants for the fc_argmax classification head.
package fc_argmax_pkg;

    localparam int LOGIT_W = 8;

    // One below the int8 range, so the first compared logit always claims the runner-up slot.
    localparam logic signed [LOGIT_W:0] SECOND_SENTINEL = -9'sd129;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running best (and optional runner-up, ARGMAX_TOP2_EN) tracker; exposes the post-update values.
module argmax_tracker
    import fc_argmax_pkg::*;
#(
    parameter int CLASS_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic signed [LOGIT_W-1:0] load_val,
    input  logic signed [LOGIT_W-1:0] cand_val,
    input  logic [CLASS_W-1:0]        cand_idx,
    output logic signed [LOGIT_W-1:0] nxt_best_val,
    output logic [CLASS_W-1:0]        nxt_best_idx
`ifdef ARGMAX_TOP2_EN
    ,
    output logic signed [LOGIT_W-1:0] nxt_second_val,
    output logic [CLASS_W-1:0]        nxt_second_idx
`endif
);

    logic signed [LOGIT_W-1:0] best_val_q, best_val_d;
    logic [CLASS_W-1:0]        best_idx_q, best_idx_d;

`ifdef ARGMAX_TOP2_EN
    logic signed [LOGIT_W:0]   second_val_q, second_val_d;
    logic [CLASS_W-1:0]        second_idx_q, second_idx_d;
    logic signed [LOGIT_W:0]   cand_ext_s;

    assign cand_ext_s = $signed({cand_val[LOGIT_W-1], cand_val});
`endif

    // Strict greater-than keeps the lower index on ties because channels arrive in ascending order.
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
`ifdef ARGMAX_TOP2_EN
        second_val_d = second_val_q;
        second_idx_d = second_idx_q;
`endif
        if (load) begin
            best_val_d = load_val;
            best_idx_d = '0;
`ifdef ARGMAX_TOP2_EN
            second_val_d = SECOND_SENTINEL;
            second_idx_d = '0;
`endif
        end else if (step) begin
            if (cand_val > best_val_q) begin
`ifdef ARGMAX_TOP2_EN
                second_val_d = $signed({best_val_q[LOGIT_W-1], best_val_q});
                second_idx_d = best_idx_q;
`endif
                best_val_d = cand_val;
                best_idx_d = cand_idx;
            end
`ifdef ARGMAX_TOP2_EN
            else if (cand_ext_s > second_val_q) begin
                second_val_d = cand_ext_s;
                second_idx_d = cand_idx;
            end else begin
                second_val_d = second_val_q;
            end
`else
            else begin
                best_val_d = best_val_q;
            end
`endif
        end else begin
            best_val_d = best_val_q;
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_val_q <= '0;
            best_idx_q <= '0;
`ifdef ARGMAX_TOP2_EN
            second_val_q <= '0;
            second_idx_q <= '0;
`endif
        end else begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
`ifdef ARGMAX_TOP2_EN
            second_val_q <= second_val_d;
            second_idx_q <= second_idx_d;
`endif
        end
    end

    assign nxt_best_val = best_val_d;
    assign nxt_best_idx = best_idx_d;
`ifdef ARGMAX_TOP2_EN
    assign nxt_second_val = second_val_d[LOGIT_W-1:0];
    assign nxt_second_idx = second_idx_d;
`endif

endmodule

// File: rtl/fc_argmax.sv
// Serial argmax over the fc logit vector with valid/ready result hold and sticky drop flag.
// Optional runner-up outputs are enabled by defining ARGMAX_TOP2_EN.
module fc_argmax
    import fc_argmax_pkg::*;
#(
    parameter int NUM_CLASS = 43,
    parameter int CLASS_W   = $clog2(NUM_CLASS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LOGIT_W*NUM_CLASS-1:0]  i_data,
    input  logic                          i_valid,
    output logic [CLASS_W-1:0]            o_class,
    output logic signed [LOGIT_W-1:0]     o_score,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          busy,
    output logic                          overflow,
    input  logic                          clr_overflow
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [CLASS_W-1:0]            o_class2,
    output logic signed [LOGIT_W-1:0]     o_score2
`endif
);

    localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASS - 1);
    localparam logic [CLASS_W-1:0] IDX_ONE  = CLASS_W'(1);

    state_t                         state_q, state_d;
    logic [LOGIT_W*NUM_CLASS-1:0]   vec_q, vec_d;
    logic [CLASS_W-1:0]             idx_q, idx_d;
    logic [CLASS_W-1:0]             o_class_q, o_class_d;
    logic signed [LOGIT_W-1:0]      o_score_q, o_score_d;
    logic                           o_valid_q, o_valid_d;
    logic                           busy_q, busy_d;
    logic                           overflow_q, overflow_d;
    logic                           load_s, step_s, drop_s;
    logic signed [LOGIT_W-1:0]      cand_val_s, nxt_val_s;
    logic [CLASS_W-1:0]             nxt_idx_s;
`ifdef ARGMAX_TOP2_EN
    logic [CLASS_W-1:0]             o_class2_q, o_class2_d;
    logic signed [LOGIT_W-1:0]      o_score2_q, o_score2_d;
    logic signed [LOGIT_W-1:0]      nxt_val2_s;
    logic [CLASS_W-1:0]             nxt_idx2_s;
`endif

    assign cand_val_s = vec_q[int'(idx_q)*LOGIT_W +: LOGIT_W];
    assign drop_s     = i_valid && ((state_q == ST_SCAN) || ((state_q == ST_HOLD) && !i_ready));

    argmax_tracker #(.CLASS_W(CLASS_W)) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .load         (load_s),
        .step         (step_s),
        .load_val     (i_data[LOGIT_W-1:0]),
        .cand_val     (cand_val_s),
        .cand_idx     (idx_q),
        .nxt_best_val (nxt_val_s),
        .nxt_best_idx (nxt_idx_s)
`ifdef ARGMAX_TOP2_EN
        ,
        .nxt_second_val (nxt_val2_s),
        .nxt_second_idx (nxt_idx2_s)
`endif
    );

    // Next-state, capture and result-latch logic; results update only on the edge entering HOLD.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        idx_d     = idx_q;
        o_class_d = o_class_q;
        o_score_d = o_score_q;
        load_s    = 1'b0;
        step_s    = 1'b0;
`ifdef ARGMAX_TOP2_EN
        o_class2_d = o_class2_q;
        o_score2_d = o_score2_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    vec_d   = i_data;
                    load_s  = 1'b1;
                    idx_d   = IDX_ONE;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                step_s = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d   = ST_HOLD;
                    o_class_d = nxt_idx_s;
                    o_score_d = nxt_val_s;
`ifdef ARGMAX_TOP2_EN
                    o_class2_d = nxt_idx2_s;
                    o_score2_d = nxt_val2_s;
`endif
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            ST_HOLD: begin
                if (i_ready && i_valid) begin
                    vec_d   = i_data;
                    load_s  = 1'b1;
                    idx_d   = IDX_ONE;
                    state_d = ST_SCAN;
                end else if (i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        o_valid_d = (state_d == ST_HOLD);
        busy_d    = (state_d != ST_IDLE);

        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control, vector and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            idx_q      <= '0;
            o_class_q  <= '0;
            o_score_q  <= '0;
            o_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            o_class2_q <= '0;
            o_score2_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            idx_q      <= idx_d;
            o_class_q  <= o_class_d;
            o_score_q  <= o_score_d;
            o_valid_q  <= o_valid_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
`ifdef ARGMAX_TOP2_EN
            o_class2_q <= o_class2_d;
            o_score2_q <= o_score2_d;
`endif
        end
    end

    assign o_class  = o_class_q;
    assign o_score  = o_score_q;
    assign o_valid  = o_valid_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
`ifdef ARGMAX_TOP2_EN
    assign o_class2 = o_class2_q;
    assign o_score2 = o_score2_q;
`endif

endmodule
